// File: rtl/polyfir_pkg.sv
// Shared types and helpers for the time-multiplexed decimating FIR.
// Holds the sequencer state encoding and the default datapath widths.
package polyfir_pkg;

  localparam int DEF_WIDTH_IN   = 8;
  localparam int DEF_WIDTH_COEF = 10;
  localparam int DEF_WIDTH_OUT  = 20;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/polyfir_ring_buf.sv
// TAPS-deep register delay line: wrapping write port and a registered read
// port addressed by tap offset back from the most recently written entry.
module polyfir_ring_buf
  import polyfir_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int TAPS   = 21,
  parameter int ADDR_W = clog2(TAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_offset,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int AW1 = ADDR_W + 1;

  logic [WIDTH-1:0]  mem [TAPS];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] newest;
  logic [ADDR_W-1:0] rd_idx;

  // Read index is (newest - offset) mod TAPS; widen before adding TAPS back.
  always_comb begin
    rd_idx = newest - rd_offset;
    if (newest < rd_offset) begin
      rd_idx = ADDR_W'(AW1'(newest) + AW1'(TAPS) - AW1'(rd_offset));
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  // NOTE: the delay line is clearable flops, not RAM, so it may be reset;
  // the first outputs rely on a zeroed history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      newest  <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        newest      <= wr_ptr;
        wr_ptr      <= (wr_ptr == ADDR_W'(TAPS - 1)) ? '0 : wr_ptr + ADDR_W'(1);
      end
      if (rd_en) rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/polyfir_decim_sched.sv
// Decimating FIR controller: collects DECIM samples, then runs one TAPS-long
// single-multiplier MAC pass against an external 1-cycle-latency ROM.
module polyfir_decim_sched
  import polyfir_pkg::*;
#(
  parameter int WIDTH_IN   = DEF_WIDTH_IN,
  parameter int WIDTH_COEF = DEF_WIDTH_COEF,
  parameter int WIDTH_OUT  = DEF_WIDTH_OUT,
  parameter int TAPS       = 21,
  parameter int DECIM      = 4,
  parameter int ADDR_W     = clog2(TAPS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH_IN-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_W-1:0]     coef_addr,
  input  logic [WIDTH_COEF-1:0] coef_data,
  output logic [WIDTH_OUT-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int PW   = WIDTH_IN + WIDTH_COEF;
  localparam int PH_W = (DECIM > 1) ? clog2(DECIM) : 1;

  state_t state, state_nxt;

  logic [PH_W-1:0]             phase;
  logic [ADDR_W-1:0]           k;
  logic                        accept, last_phase, last_tap;
  logic signed [WIDTH_IN-1:0]  sample;
  logic                        mac_vld, mac_first;
  logic signed [PW-1:0]        prod;
  logic signed [WIDTH_OUT-1:0] prod_ext, acc;

  assign in_ready   = (state == FILL);
  assign coef_addr  = k;
  assign accept     = in_valid && in_ready;
  assign last_phase = (phase == PH_W'(DECIM - 1));
  assign last_tap   = (k == ADDR_W'(TAPS - 1));

  polyfir_ring_buf #(
    .WIDTH  (WIDTH_IN),
    .TAPS   (TAPS),
    .ADDR_W (ADDR_W)
  ) u_ring (
    .clk       (clk),
    .reset     (reset),
    .wr_data   (in_data),
    .wr_en     (accept),
    .rd_en     (state == RUN),
    .rd_offset (k),
    .rd_data   (sample)
  );

  // sample and coef_data are both registered reads of tap k, so they pair up.
  assign prod     = sample * $signed(coef_data);
  assign prod_ext = WIDTH_OUT'(prod);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_nxt;
  end

  // NOTE: defaulting state_nxt before the case keeps this block latch-free.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:    if (accept && last_phase)    state_nxt = RUN;
      RUN:     if (last_tap)                state_nxt = DRAIN;
      DRAIN:                                state_nxt = HOLD;
      HOLD:    if (out_valid && out_ready)  state_nxt = FILL;
      default:                              state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase     <= '0;
      k         <= '0;
      mac_vld   <= 1'b0;
      mac_first <= 1'b0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) phase <= last_phase ? '0 : phase + PH_W'(1);
      if (state == RUN) k <= last_tap ? '0 : k + ADDR_W'(1);

      mac_vld   <= (state == RUN);
      mac_first <= (state == RUN) && (k == '0);
      if (mac_vld) acc <= mac_first ? prod_ext : acc + prod_ext;

      // First HOLD cycle captures the finished sum; it then waits for out_ready.
      if (state == HOLD) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_data  <= acc;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_polyfir_decim_sched.sv
// Self-checking bench: behavioural FIR model with latency scoreboard, plus
// directed impulse/DC/extreme/backpressure/reset cases and a random soak.
module tb_polyfir_decim_sched;

  localparam int TAPS = 21, DECIM = 4, WI = 8, WC = 10, WO = 20, AW = 5;

  typedef struct {
    int y;
    int due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [WI-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] coef_addr;
  logic [WC-1:0] coef_data = '0;
  logic [WO-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;

  int   h[TAPS];
  int   hist[TAPS];
  exp_t exp_q[$];
  int   out_log[$];
  int   n_acc = 0;
  bit   prev_hold = 1'b0;
  logic [WO-1:0] prev_data = '0;
  int   cyc = 0;
  int   or_mode = 0;
  bit   bp_val = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  polyfir_decim_sched #(
    .WIDTH_IN(WI), .WIDTH_COEF(WC), .WIDTH_OUT(WO), .TAPS(TAPS), .DECIM(DECIM), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .coef_addr(coef_addr), .coef_data(coef_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always @(posedge clk) coef_data <= WC'(h[coef_addr]);
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(1));
      default: out_ready = bp_val;
    endcase
  end

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int sx_out(input logic [WO-1:0] v);
    return int'($signed(v));
  endfunction

  // Direct convolution over the last TAPS accepted samples, wrapped to WO bits.
  function automatic int model_y();
    longint s;
    logic [WO-1:0] w;
    s = 0;
    for (int i = 0; i < TAPS; i++) s += longint'(h[i]) * longint'(hist[i]);
    w = s[WO-1:0];
    return int'($signed(w));
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      foreach (hist[i]) hist[i] = 0;
      exp_q.delete();
      n_acc     = 0;
      prev_hold = 1'b0;
      check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
      check(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
    end else begin
      if (out_valid) begin
        if (!prev_hold) begin
          check(exp_q.size() > 0, "unexpected_output", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            check(sx_out(out_data) == exp_q[0].y, "out_data", sx_out(out_data), exp_q[0].y);
            check(cyc == exp_q[0].due, "latency_edge", cyc, exp_q[0].due);
          end
        end else begin
          check(out_data == prev_data, "hold_stable", out_data, prev_data);
        end
        check(in_ready == 1'b0, "in_ready_in_hold", in_ready, 0);
        if (out_ready) begin
          out_log.push_back(sx_out(out_data));
          if (exp_q.size() > 0) exp_q.delete(0);
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        check(out_valid == 1'b1, "late_output", out_valid, 1);
        exp_q.delete(0);
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (in_valid && in_ready) begin
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'($signed(in_data));
        n_acc++;
        if (n_acc % DECIM == 0) exp_q.push_back('{model_y(), cyc + 1 + TAPS + 2});
      end
    end
  end

  // Called and returns at posedge+1; leaves in_valid high for back-to-back use.
  task automatic send(input int x, input int gap);
    int n;
    n = 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    in_data  = WI'(x);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(in_ready == 1'b1, "accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || !in_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b0;
    repeat (2) @(negedge clk);
    check(out_data == '0, "rst_out_data", out_data, 0);
    check(coef_addr == '0, "rst_coef_addr", coef_addr, 0);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string name, input int base, input int expv[$]);
    check(out_log.size() - base == expv.size(), {name, "_count"}, out_log.size() - base, expv.size());
    for (int i = 0; i < expv.size(); i++) begin
      if (base + i < out_log.size())
        check(out_log[base+i] == expv[i], $sformatf("%s[%0d]", name, i), out_log[base+i], expv[i]);
    end
  endtask

  task automatic set_h_ramp();
    for (int i = 0; i < TAPS; i++) h[i] = i + 1;
  endtask

  task automatic set_h_rand();
    for (int i = 0; i < TAPS; i++) h[i] = int'($urandom_range(1023)) - 512;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time=%0t required=finish before 500000", $time);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int base;
    int n;
    int expv[$];

    #3;
    set_h_ramp();
    do_reset();

    // Impulse through ramp coefficients.
    base = out_log.size();
    send(1, 0);
    repeat (27) send(0, 0);
    in_valid = 1'b0;
    wait_idle();
    expv = '{4, 8, 12, 16, 20, 0, 0};
    check_log("impulse", base, expv);

    // DC response builds up from zero history.
    do_reset();
    base = out_log.size();
    repeat (28) send(1, 0);
    in_valid = 1'b0;
    wait_idle();
    expv = '{10, 36, 78, 136, 210, 231, 231};
    check_log("dc", base, expv);

    // Most negative input against large positive coefficients.
    for (int i = 0; i < TAPS; i++) h[i] = (i < 8) ? 255 : 0;
    do_reset();
    base = out_log.size();
    repeat (16) send(-128, 0);
    in_valid = 1'b0;
    wait_idle();
    expv = '{-130560, -261120, -261120, -261120};
    check_log("neg_extreme", base, expv);
    check(out_data == 20'hC0400, "neg_raw", out_data, 20'hC0400);

    // Backpressure: downstream stalls 10 cycles while more samples are offered.
    set_h_rand();
    base    = out_log.size();
    bp_val  = 1'b0;
    or_mode = 2;
    fork
      begin
        for (int i = 0; i < 8; i++) send(int'($urandom_range(255)) - 128, 0);
        in_valid = 1'b0;
      end
      begin
        n = 0;
        while (!out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        check(out_valid == 1'b1, "bp_first_valid", out_valid, 1);
        repeat (10) begin
          @(negedge clk);
          check(out_valid == 1'b1, "bp_valid_held", out_valid, 1);
          check(in_ready == 1'b0, "bp_in_ready_low", in_ready, 0);
        end
        bp_val = 1'b1;
      end
    join
    wait_idle();
    check(out_log.size() - base == 2, "bp_count", out_log.size() - base, 2);
    or_mode = 0;

    // Random soak with input gaps and random downstream readiness.
    set_h_rand();
    base    = out_log.size();
    or_mode = 1;
    for (int i = 0; i < 80; i++) send(int'($urandom_range(255)) - 128, int'($urandom_range(2)));
    in_valid = 1'b0;
    wait_idle();
    check(out_log.size() - base == 20, "rand_count", out_log.size() - base, 20);
    or_mode = 0;

    // Reset in the middle of a pass, then the impulse must replay cleanly.
    set_h_ramp();
    do_reset();
    send(7, 0);
    repeat (3) send(5, 0);
    in_valid = 1'b0;
    n = 0;
    while (coef_addr != AW'(10) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(coef_addr == AW'(10), "reach_k10", coef_addr, 10);
    #2 reset = 1'b0;
    #1;
    check(out_valid == 1'b0, "midrst_out_valid", out_valid, 0);
    check(in_ready == 1'b1, "midrst_in_ready", in_ready, 1);
    check(coef_addr == '0, "midrst_coef_addr", coef_addr, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    base = out_log.size();
    send(1, 0);
    repeat (19) send(0, 0);
    in_valid = 1'b0;
    wait_idle();
    expv = '{4, 8, 12, 16, 20};
    check_log("post_reset_impulse", base, expv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
